ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/ssd_scan_driver.sv | 154 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: glyphs, blank pattern,
// controller state encoding and BCD sizing.
package ssd_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } scan_state_t;

  localparam logic [7:0] BLANK_CATH = 8'hFF;

  // {a,b,c,d,e,f,g}, active-low; entry [n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // ceil(bits * log10(2)), enough decimal digits for any bits-wide value.
  function automatic int bcd_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// done and bcd are combinational on the final step so the caller can commit on that edge.
module bin2bcd_seq #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] acc_adj;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd  = {acc_adj[BCD_W-2:0], sh_q[BIN_W-1]};
  assign done = busy && (cnt_q == '0);

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      busy  <= 1'b0;
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      sh_q  <= bin;
      acc_q <= '0;
      cnt_q <= CNT_W'(BIN_W - 1);
    end else if (busy) begin
      sh_q  <= sh_q << 1;
      acc_q <= bcd;
      if (cnt_q == '0) busy <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with hex/decimal load, leading-zero
// blanking and registered anode/cathode outputs.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV_BITS = 18,
  parameter int VALUE_W       = 16
) (
  input  logic                  board_clk,
  input  logic                  Reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  mode_dec,
  input  logic                  lz_blank,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            cathodes,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_DIGITS = bcd_digits(VALUE_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int DISP_W     = 4 * NUM_DIGITS;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t              state_q;
  logic [SCAN_DIV_BITS-1:0] presc_q;
  logic [IDX_W-1:0]         idx_q;
  logic [DISP_W-1:0]        disp_q;
  logic                     lz_q;
  logic                     lz_pend_q;

  logic                     accept;
  logic                     conv_busy;
  logic                     conv_done;
  logic [BCD_W-1:0]         conv_bcd;
  logic [DISP_W-1:0]        hex_disp;
  logic [DISP_W-1:0]        dec_disp;
  logic                     dec_ovf;
  logic [NUM_DIGITS-1:0]    blank;
  logic [3:0]               cur_nib;
  logic                     show;

  assign value_ready = (state_q == IDLE) && !conv_busy;
  assign busy        = (state_q == CONVERT);
  assign accept      = value_valid && value_ready;

  bin2bcd_seq #(
    .BIN_W      (VALUE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .board_clk (board_clk),
    .Reset     (Reset),
    .start     (accept && mode_dec),
    .bin       (value),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (conv_bcd)
  );

  // Fit the hex value and the BCD result to the display width.
  if (VALUE_W >= DISP_W) begin : g_hex_trunc
    assign hex_disp = value[DISP_W-1:0];
  end else begin : g_hex_ext
    assign hex_disp = {{(DISP_W - VALUE_W){1'b0}}, value};
  end

  if (BCD_W > DISP_W) begin : g_bcd_trunc
    assign dec_disp = conv_bcd[DISP_W-1:0];
    assign dec_ovf  = |conv_bcd[BCD_W-1:DISP_W];
  end else if (BCD_W == DISP_W) begin : g_bcd_fit
    assign dec_disp = conv_bcd;
    assign dec_ovf  = 1'b0;
  end else begin : g_bcd_ext
    assign dec_disp = {{(DISP_W - BCD_W){1'b0}}, conv_bcd};
    assign dec_ovf  = 1'b0;
  end

  // A digit is blanked when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_above = nz_above | (disp_q[4*k +: 4] != 4'd0);
      blank[k] = lz_q && (k != 0) && !nz_above;
    end
  end

  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];
  assign show    = digit_en[idx_q] && !blank[idx_q];

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      an       <= '1;
      cathodes <= BLANK_CATH;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) begin
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_q <= '0;
        else                                 idx_q <= idx_q + 1'b1;
      end
      if (show) begin
        an       <= ~(NUM_DIGITS'(1) << idx_q);
        cathodes <= {GLYPH_TBL[cur_nib], ~dp_mask[idx_q]};
      end else begin
        an       <= '1;
        cathodes <= BLANK_CATH;
      end
    end
  end

  // lz_blank is held pending during conversion so the old display keeps its own blanking.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      disp_q    <= '0;
      lz_q      <= 1'b0;
      lz_pend_q <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lz_pend_q <= lz_blank;
            if (mode_dec) begin
              state_q <= CONVERT;
            end else begin
              disp_q   <= hex_disp;
              lz_q     <= lz_blank;
              overflow <= 1'b0;
            end
          end
        end
        CONVERT: begin
          if (conv_done) begin
            disp_q   <= dec_disp;
            lz_q     <= lz_pend_q;
            overflow <= dec_ovf;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a short prescaler (4-clock dwell).
module tb_ssd_scan_driver;

  logic        board_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        mode_dec = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  an;
  logic [7:0]  cathodes;
  logic        busy;
  logic        overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] cap_cath [4];
  logic [3:0] cap_seen;
  int         cap_blank;
  int         cap_bad;
  logic       cap_busy;

  ssd_scan_driver #(
    .NUM_DIGITS    (4),
    .SCAN_DIV_BITS (2),
    .VALUE_W       (16)
  ) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .mode_dec    (mode_dec),
    .lz_blank    (lz_blank),
    .digit_en    (digit_en),
    .dp_mask     (dp_mask),
    .an          (an),
    .cathodes    (cathodes),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full scan period: record what each digit shows and how many slots are dark.
  task automatic capture();
    logic [3:0] onehot;
    logic       found;
    cap_seen  = '0;
    cap_blank = 0;
    cap_bad   = 0;
    cap_busy  = 1'b0;
    for (int k = 0; k < 4; k++) cap_cath[k] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge board_clk);
      if (busy) cap_busy = 1'b1;
      if (an == 4'hF) begin
        cap_blank++;
        if (cathodes != 8'hFF) cap_bad++;
      end else begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          onehot = 4'b0001 << k;
          if (an == ~onehot) begin
            found       = 1'b1;
            cap_seen[k] = 1'b1;
            cap_cath[k] = cathodes;
          end
        end
        if (!found) cap_bad++;
      end
    end
  endtask

  task automatic load(input logic [15:0] v, input logic dec, input logic lz);
    @(negedge board_clk);
    value       = v;
    mode_dec    = dec;
    lz_blank    = lz;
    value_valid = 1'b1;
    check("ready_before_load", value_ready, 1);
    @(posedge board_clk);
    #1 value_valid = 1'b0;
  endtask

  // Counts busy cycles after an accept, checking the old display stays up meanwhile.
  task automatic wait_conv(input int pulse_at, input logic [7:0] prev [4],
                           output int n, output int held_bad);
    logic [3:0] onehot;
    n        = 0;
    held_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge board_clk);
      value_valid = 1'b0;
      if (!busy) break;
      n++;
      if (value_ready) held_bad++;
      for (int k = 0; k < 4; k++) begin
        onehot = 4'b0001 << k;
        if (an == ~onehot && cathodes != prev[k]) held_bad++;
      end
      if (i == pulse_at) begin
        value       = 16'h0007;
        mode_dec    = 1'b0;
        value_valid = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int held_bad;
    int bad;
    logic [3:0] onehot;

    #20;
    check("rst_an", an, 4'hF);
    check("rst_cath", cathodes, 8'hFF);
    check("rst_ready", value_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);

    #2 Reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge board_clk);
      onehot = 4'b0001 << (i / 4);
      if (an != ~onehot || cathodes != 8'h03) bad++;
    end
    check("scan_after_reset", bad, 0);

    // Hex 0xBEEF
    load(16'hBEEF, 1'b0, 1'b0);
    @(negedge board_clk);
    check("hex_ready", value_ready, 1);
    check("hex_busy", busy, 0);
    capture();
    check("hex_busy_scan", cap_busy, 0);
    check("hex_seen", cap_seen, 4'hF);
    check("hex_bad", cap_bad, 0);
    check("hex_d0", cap_cath[0], 8'h71);
    check("hex_d1", cap_cath[1], 8'h61);
    check("hex_d2", cap_cath[2], 8'h61);
    check("hex_d3", cap_cath[3], 8'hC1);

    // Decimal 1234, digit 1 decimal point lit afterwards
    load(16'd1234, 1'b1, 1'b0);
    wait_conv(-1, '{8'h71, 8'h61, 8'h61, 8'hC1}, n, held_bad);
    check("dec1234_busy_cycles", n, 16);
    check("dec1234_held", held_bad, 0);
    dp_mask = 4'b0010;
    capture();
    check("dec1234_seen", cap_seen, 4'hF);
    check("dec1234_d0", cap_cath[0], 8'h99);
    check("dec1234_d1_dp", cap_cath[1], 8'h0C);
    check("dec1234_d2", cap_cath[2], 8'h25);
    check("dec1234_d3", cap_cath[3], 8'h9F);
    check("dec1234_ovf", overflow, 0);
    dp_mask = 4'b0000;

    // Decimal 42 with leading-zero blanking
    load(16'd42, 1'b1, 1'b1);
    wait_conv(-1, '{8'h99, 8'h0D, 8'h25, 8'h9F}, n, held_bad);
    check("dec42_busy_cycles", n, 16);
    check("dec42_held", held_bad, 0);
    capture();
    check("dec42_seen", cap_seen, 4'b0011);
    check("dec42_blank", cap_blank, 8);
    check("dec42_bad", cap_bad, 0);
    check("dec42_d0", cap_cath[0], 8'h25);
    check("dec42_d1", cap_cath[1], 8'h99);

    // Decimal 0 with blanking: only digit 0
    load(16'd0, 1'b1, 1'b1);
    wait_conv(-1, '{8'h25, 8'h99, 8'hFF, 8'hFF}, n, held_bad);
    check("dec0_held", held_bad, 0);
    capture();
    check("dec0_seen", cap_seen, 4'b0001);
    check("dec0_blank", cap_blank, 12);
    check("dec0_d0", cap_cath[0], 8'h03);

    // Decimal 65535 overflows; a hex load attempt mid-conversion is ignored
    load(16'd65535, 1'b1, 1'b0);
    wait_conv(4, '{8'h03, 8'hFF, 8'hFF, 8'hFF}, n, held_bad);
    check("dec65535_busy_cycles", n, 16);
    check("dec65535_held", held_bad, 0);
    capture();
    check("dec65535_seen", cap_seen, 4'hF);
    check("dec65535_d0", cap_cath[0], 8'h49);
    check("dec65535_d1", cap_cath[1], 8'h0D);
    check("dec65535_d2", cap_cath[2], 8'h49);
    check("dec65535_d3", cap_cath[3], 8'h49);
    check("dec65535_ovf", overflow, 1);

    // Hex load clears overflow; blanking applies; digit 0 disabled live
    digit_en = 4'b1110;
    load(16'h00A0, 1'b0, 1'b1);
    @(negedge board_clk);
    check("hexA0_ovf_clear", overflow, 0);
    capture();
    check("hexA0_seen", cap_seen, 4'b0010);
    check("hexA0_blank", cap_blank, 12);
    check("hexA0_bad", cap_bad, 0);
    check("hexA0_d1", cap_cath[1], 8'h11);
    digit_en = 4'hF;

    // Reset in the middle of a conversion
    load(16'd999, 1'b1, 1'b0);
    repeat (7) @(posedge board_clk);
    @(negedge board_clk);
    check("mid_busy_before", busy, 1);
    Reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", value_ready, 1);
    check("abort_an", an, 4'hF);
    check("abort_cath", cathodes, 8'hFF);
    @(negedge board_clk);
    Reset = 1'b0;
    @(negedge board_clk);
    check("abort_an_next", an, 4'b1110);
    check("abort_disp_zero", cathodes, 8'h03);
    check("abort_busy_next", busy, 0);
    check("abort_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
